// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: computes D = A - B (unsigned, modulo 2^WIDTH) one
//   bit per clock, LSB first, using a full subtractor, a borrow flop and
//   operand/result shift registers. Operation is started via a START/DONE
//   handshake. The sequence is IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle)
//   -> IDLE.
//
// Ports
//   clk_i    : clock, all state changes on the rising edge
//   rst_ni   : asynchronous active-low reset
//   start_i  : start request, sampled only in IDLE
//   a_i      : minuend, captured on the accepting edge
//   b_i      : subtrahend, captured on the accepting edge
//   busy_o   : high while in RUN or DONE
//   done_o   : one-cycle pulse, d_o/bo_o valid
//   d_o      : difference A - B mod 2^WIDTH
//   bo_o     : final borrow out (1 iff A < B unsigned)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bo_o
);

  localparam int          CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bo_q, bo_d;

  // Full subtractor on the current LSBs of the operand shift registers.
  logic bit_a, bit_b, diff_bit, borrow_nxt;

  assign bit_a      = sa_q[0];
  assign bit_b      = sb_q[0];
  assign diff_bit   = bit_a ^ bit_b ^ borrow_q;
  assign borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      bo_q     <= bo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    bo_d     = bo_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sa_d     = a_i;
          sb_d     = b_i;
          sr_d     = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        // Result bits enter at the MSB so that after WIDTH shifts the
        // first (LSB) difference bit has arrived at position 0.
        sr_d     = {diff_bit, sr_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Final bit processed this edge: publish the complete result,
          // including the bit being shifted in right now.
          res_d   = {diff_bit, sr_q[WIDTH-1:1]};
          bo_d    = borrow_nxt;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q == S_RUN) || (state_q == S_DONE);
  assign done_o = (state_q == S_DONE);
  assign d_o    = res_q;
  assign bo_o   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed and swept checks of serial_subtractor (WIDTH = 8): reset values,
//   latency/BUSY/DONE timing, arithmetic including boundary operands, START
//   and operand changes ignored during RUN, back-to-back operation with START
//   held high, and reset aborting a running operation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         clk_en;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d_out;
  logic         bo_out;

  int n_checks;
  int n_fail;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .a_i     (a_in),
    .b_i     (b_in),
    .busy_o  (busy),
    .done_o  (done),
    .d_o     (d_out),
    .bo_o    (bo_out)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Runs one operation from IDLE. Sample k is taken at the falling edge
  // after the k-th rising edge counted from the accepting edge (k = 0).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic bo,
                       output int done_at, output int npulse, output int nbusy);
    d = 'x;
    bo = 1'bx;
    done_at = -1;
    npulse = 0;
    nbusy = 0;
    @(negedge clk);
    a_in = a;
    b_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (busy) nbusy++;
      if (done) begin
        npulse++;
        if (done_at < 0) begin
          done_at = k;
          d = d_out;
          bo = bo_out;
        end
      end
      if (k < 13) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    // Clock is still stopped here: values must come from the async reset.
    n_checks++;
    if ({busy, done, d_out, bo_out} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b done=%b d=%h bo=%b, required 0 0 00 0",
               busy, done, d_out, bo_out);
    end
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, d_out, bo_out} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b done=%b d=%h bo=%b, required 0 0 00 0",
               busy, done, d_out, bo_out);
    end
    $display("reset: busy=%b done=%b d=%h bo=%b", busy, done, d_out, bo_out);
  endtask

  task automatic test_basic();
    logic [W-1:0] d;
    logic bo;
    int done_at, npulse, nbusy;
    do_op(8'd5, 8'd3, d, bo, done_at, npulse, nbusy);
    $display("op 05-03: d=%h bo=%b done_at=%0d pulses=%0d busy_cycles=%0d",
             d, bo, done_at, npulse, nbusy);
    n_checks++;
    if (d !== 8'h02 || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: d=%h bo=%b, required 02 0", d, bo);
    end
    n_checks++;
    if (done_at !== W) begin
      n_fail++;
      $display("FAIL basic_latency: done at sample %0d, required %0d", done_at, W);
    end
    n_checks++;
    if (nbusy !== W + 1 || npulse !== 1) begin
      n_fail++;
      $display("FAIL basic_busy: busy cycles %0d pulses %0d, required %0d 1",
               nbusy, npulse, W + 1);
    end
    // Result must hold while idle.
    repeat (3) @(negedge clk);
    n_checks++;
    if (d_out !== 8'h02 || bo_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: d=%h bo=%b busy=%b, required 02 0 0", d_out, bo_out, busy);
    end
  endtask

  task automatic test_borrow();
    logic [W-1:0] av [2] = '{8'd3, 8'd0};
    logic [W-1:0] bv [2] = '{8'd5, 8'd1};
    logic [W-1:0] de [2] = '{8'hFE, 8'hFF};
    logic [W-1:0] d;
    logic bo;
    int done_at, npulse, nbusy;
    for (int i = 0; i < 2; i++) begin
      do_op(av[i], bv[i], d, bo, done_at, npulse, nbusy);
      $display("op %h-%h: d=%h bo=%b done_at=%0d", av[i], bv[i], d, bo, done_at);
      n_checks++;
      if (d !== de[i] || bo !== 1'b1 || done_at !== W) begin
        n_fail++;
        $display("FAIL borrow_%0d: d=%h bo=%b done_at=%0d, required %h 1 %0d",
                 i, d, bo, done_at, de[i], W);
      end
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] av [3] = '{8'hFF, 8'h00, 8'h80};
    logic [W-1:0] bv [3] = '{8'hFF, 8'h00, 8'h7F};
    logic [W-1:0] de [3] = '{8'h00, 8'h00, 8'h01};
    logic [W-1:0] d;
    logic bo;
    int done_at, npulse, nbusy;
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], d, bo, done_at, npulse, nbusy);
      $display("op %h-%h: d=%h bo=%b done_at=%0d", av[i], bv[i], d, bo, done_at);
      n_checks++;
      if (d !== de[i] || bo !== 1'b0 || done_at !== W) begin
        n_fail++;
        $display("FAIL boundary_%0d: d=%h bo=%b done_at=%0d, required %h 0 %0d",
                 i, d, bo, done_at, de[i], W);
      end
    end
  endtask

  task automatic test_ignore_in_run();
    int npulse = 0;
    int done_at = -1;
    logic [W-1:0] d = 'x;
    logic bo = 1'bx;
    @(negedge clk);
    a_in = 8'h10;
    b_in = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      // Re-request and disturb the operands in the middle of RUN.
      if (k == 2) begin
        start = 1'b1;
        a_in = 8'hAA;
        b_in = 8'h55;
      end
      if (k == 5) start = 1'b0;
      if (done) begin
        npulse++;
        if (done_at < 0) begin
          done_at = k;
          d = d_out;
          bo = bo_out;
        end
      end
      if (k < 13) @(negedge clk);
    end
    $display("op 10-01 disturbed: d=%h bo=%b done_at=%0d pulses=%0d", d, bo, done_at, npulse);
    n_checks++;
    if (d !== 8'h0F || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: d=%h bo=%b, required 0f 0", d, bo);
    end
    n_checks++;
    if (npulse !== 1 || done_at !== W) begin
      n_fail++;
      $display("FAIL ignore_pulses: pulses=%0d done_at=%0d, required 1 %0d", npulse, done_at, W);
    end
  endtask

  task automatic test_back_to_back();
    int times [$];
    int idle_wait = 0;
    @(negedge clk);
    a_in = 8'h09;
    b_in = 8'h04;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 35; k++) begin
      if (done) times.push_back(k);
      if (k < 34) @(negedge clk);
    end
    start = 1'b0;
    $display("back_to_back: %0d pulses, first at %0d", times.size(),
             (times.size() > 0) ? times[0] : -1);
    n_checks++;
    if (times.size() !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: pulses=%0d, required 3", times.size());
    end else begin
      n_checks++;
      if (times[0] !== W || times[1] - times[0] !== W + 2 || times[2] - times[1] !== W + 2) begin
        n_fail++;
        $display("FAIL b2b_spacing: pulses at %0d %0d %0d, required %0d %0d %0d",
                 times[0], times[1], times[2], W, 2 * W + 2, 3 * W + 4);
      end
      n_checks++;
      if (d_out !== 8'h05) begin
        n_fail++;
        $display("FAIL b2b_result: d=%h, required 05", d_out);
      end
    end
    while (busy && idle_wait < 20) begin
      @(negedge clk);
      idle_wait++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] d;
    logic bo;
    int done_at, npulse, nbusy;
    int spurious = 0;
    do_op(8'd3, 8'd5, d, bo, done_at, npulse, nbusy);   // leaves d_o = FE, bo_o = 1
    @(negedge clk);
    a_in = 8'h55;
    b_in = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);                           // fourth RUN cycle
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, d_out, bo_out} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_clear: busy=%b done=%b d=%h bo=%b, required 0 0 00 0",
               busy, done, d_out, bo_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    $display("abort: spurious busy/done cycles=%0d", spurious);
    n_checks++;
    if (spurious !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d busy/done cycles after abort, required 0", spurious);
    end
    do_op(8'd7, 8'd2, d, bo, done_at, npulse, nbusy);
    $display("op 07-02: d=%h bo=%b done_at=%0d", d, bo, done_at);
    n_checks++;
    if (d !== 8'h05 || bo !== 1'b0 || done_at !== W) begin
      n_fail++;
      $display("FAIL abort_recover: d=%h bo=%b done_at=%0d, required 05 0 %0d", d, bo, done_at, W);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, d, exp_d;
    logic bo, exp_bo;
    int done_at, npulse, nbusy;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      exp_d = a - b;
      exp_bo = (a < b);
      do_op(a, b, d, bo, done_at, npulse, nbusy);
      n_checks++;
      if (d !== exp_d || bo !== exp_bo || done_at !== W || npulse !== 1) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: %h-%h d=%h bo=%b done_at=%0d pulses=%0d, required %h %b %0d 1",
                   i, a, b, d, bo, done_at, npulse, exp_d, exp_bo, W);
      end
    end
    $display("random sweep: 1000 operations, %0d wrong", bad);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    clk_en = 1'b0;
    rst_n = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    test_reset();
    test_basic();
    test_borrow();
    test_boundary();
    test_ignore_in_run();
    test_back_to_back();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
